// File: rtl/dmem_arbiter.sv
// Two-port (CPU / loader) arbiter and sequencer for a single-port data memory.
// Round-robin by default; define DMEM_ARB_CPU_PRIO_EN for fixed CPU priority.
module dmem_arbiter #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic              ldr_gnt,
    output logic              ldr_rvalid,
    output logic [DATA_W-1:0] ldr_rdata,
    output logic              ena,
    output logic              wea,
    output logic [ADDR_W-1:0] addra,
    output logic [DATA_W-1:0] dina,
    input  logic [DATA_W-1:0] douta,
    output logic              busy
);

    typedef enum logic [0:0] {IDLE, RD_WAIT} state_t;

    state_t            state_reg, state_next;
    logic [1:0]        cnt_reg, cnt_next;
    logic              owner_cpu_reg, owner_cpu_next;
    logic              ena_reg, ena_next;
    logic              wea_reg, wea_next;
    logic [ADDR_W-1:0] addra_reg, addra_next;
    logic [DATA_W-1:0] dina_reg, dina_next;
    logic              cpu_gnt_reg, cpu_gnt_next;
    logic              ldr_gnt_reg, ldr_gnt_next;
    logic              cpu_rvalid_reg, cpu_rvalid_next;
    logic              ldr_rvalid_reg, ldr_rvalid_next;
    logic [DATA_W-1:0] cpu_rdata_reg, cpu_rdata_next;
    logic [DATA_W-1:0] ldr_rdata_reg, ldr_rdata_next;
    logic              busy_reg, busy_next;
    logic              any_req;
    logic              pick_cpu;
    logic              win_we;

`ifdef DMEM_ARB_CPU_PRIO_EN
    assign pick_cpu = cpu_req;
`else
    logic last_cpu_reg, last_cpu_next;

    // The port that won last time yields on a tie.
    assign pick_cpu = cpu_req & (~ldr_req | ~last_cpu_reg);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_cpu_reg <= 1'b0;
        end else begin
            last_cpu_reg <= last_cpu_next;
        end
    end
`endif

    assign any_req = cpu_req | ldr_req;
    assign win_we  = pick_cpu ? cpu_we : ldr_we;

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        owner_cpu_next  = owner_cpu_reg;
        ena_next        = 1'b0;
        wea_next        = 1'b0;
        addra_next      = addra_reg;
        dina_next       = dina_reg;
        cpu_gnt_next    = 1'b0;
        ldr_gnt_next    = 1'b0;
        cpu_rvalid_next = 1'b0;
        ldr_rvalid_next = 1'b0;
        cpu_rdata_next  = cpu_rdata_reg;
        ldr_rdata_next  = ldr_rdata_reg;
        busy_next       = busy_reg;
`ifndef DMEM_ARB_CPU_PRIO_EN
        last_cpu_next   = last_cpu_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (any_req) begin
                    ena_next     = 1'b1;
                    wea_next     = win_we;
                    addra_next   = pick_cpu ? cpu_addr : ldr_addr;
                    dina_next    = pick_cpu ? cpu_wdata : ldr_wdata;
                    cpu_gnt_next = pick_cpu;
                    ldr_gnt_next = ~pick_cpu;
`ifndef DMEM_ARB_CPU_PRIO_EN
                    last_cpu_next = pick_cpu;
`endif
                    if (!win_we) begin
                        state_next     = RD_WAIT;
                        cnt_next       = 2'(RD_LAT);
                        owner_cpu_next = pick_cpu;
                        busy_next      = 1'b1;
                    end
                end
            end
            RD_WAIT: begin
                // The issue cycle itself sits in RD_WAIT, so douta is ready once the count runs out.
                if (cnt_reg == 2'd0) begin
                    state_next = IDLE;
                    busy_next  = 1'b0;
                    if (owner_cpu_reg) begin
                        cpu_rvalid_next = 1'b1;
                        cpu_rdata_next  = douta;
                    end else begin
                        ldr_rvalid_next = 1'b1;
                        ldr_rdata_next  = douta;
                    end
                end else begin
                    cnt_next = cnt_reg - 2'd1;
                end
            end
            default: begin
                state_next = IDLE;
                busy_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            cnt_reg        <= 2'd0;
            owner_cpu_reg  <= 1'b0;
            ena_reg        <= 1'b0;
            wea_reg        <= 1'b0;
            addra_reg      <= '0;
            dina_reg       <= '0;
            cpu_gnt_reg    <= 1'b0;
            ldr_gnt_reg    <= 1'b0;
            cpu_rvalid_reg <= 1'b0;
            ldr_rvalid_reg <= 1'b0;
            cpu_rdata_reg  <= '0;
            ldr_rdata_reg  <= '0;
            busy_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            owner_cpu_reg  <= owner_cpu_next;
            ena_reg        <= ena_next;
            wea_reg        <= wea_next;
            addra_reg      <= addra_next;
            dina_reg       <= dina_next;
            cpu_gnt_reg    <= cpu_gnt_next;
            ldr_gnt_reg    <= ldr_gnt_next;
            cpu_rvalid_reg <= cpu_rvalid_next;
            ldr_rvalid_reg <= ldr_rvalid_next;
            cpu_rdata_reg  <= cpu_rdata_next;
            ldr_rdata_reg  <= ldr_rdata_next;
            busy_reg       <= busy_next;
        end
    end

    assign ena        = ena_reg;
    assign wea        = wea_reg;
    assign addra      = addra_reg;
    assign dina       = dina_reg;
    assign cpu_gnt    = cpu_gnt_reg;
    assign ldr_gnt    = ldr_gnt_reg;
    assign cpu_rvalid = cpu_rvalid_reg;
    assign ldr_rvalid = ldr_rvalid_reg;
    assign cpu_rdata  = cpu_rdata_reg;
    assign ldr_rdata  = ldr_rdata_reg;
    assign busy       = busy_reg;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: instance 0 uses RD_LAT=1, instance 1 uses RD_LAT=3,
// each with its own memory; outputs are checked every cycle against a cycle-count model.
module tb_dmem_arbiter;

    localparam int NI = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req[NI], cpu_we[NI], ldr_req[NI], ldr_we[NI];
    logic [6:0]  cpu_addr[NI], ldr_addr[NI], addra[NI];
    logic [31:0] cpu_wdata[NI], ldr_wdata[NI], dina[NI], douta[NI];
    logic [31:0] cpu_rdata[NI], ldr_rdata[NI];
    logic        cpu_gnt[NI], ldr_gnt[NI], cpu_rvalid[NI], ldr_rvalid[NI];
    logic        ena[NI], wea[NI], busy[NI];

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int k);
        return 32'h9E37_79B9 * 32'(k + 1);
    endfunction

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    for (genvar gi = 0; gi < NI; gi++) begin : g_inst
        localparam int L = (gi == 0) ? 1 : 3;
        logic [31:0] mem [128];
        logic [31:0] pipe [3];

        dmem_arbiter #(.ADDR_W(7), .DATA_W(32), .RD_LAT(L)) u_dut (
            .clk(clk), .reset(rst),
            .cpu_req(cpu_req[gi]), .cpu_we(cpu_we[gi]), .cpu_addr(cpu_addr[gi]),
            .cpu_wdata(cpu_wdata[gi]), .cpu_gnt(cpu_gnt[gi]), .cpu_rvalid(cpu_rvalid[gi]),
            .cpu_rdata(cpu_rdata[gi]),
            .ldr_req(ldr_req[gi]), .ldr_we(ldr_we[gi]), .ldr_addr(ldr_addr[gi]),
            .ldr_wdata(ldr_wdata[gi]), .ldr_gnt(ldr_gnt[gi]), .ldr_rvalid(ldr_rvalid[gi]),
            .ldr_rdata(ldr_rdata[gi]),
            .ena(ena[gi]), .wea(wea[gi]), .addra(addra[gi]), .dina(dina[gi]),
            .douta(douta[gi]), .busy(busy[gi])
        );

        // Single-port RAM with an L-cycle registered read path.
        always @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int k = 0; k < 128; k++) mem[k] <= init_word(k);
                for (int k = 0; k < 3; k++) pipe[k] <= 32'h0;
            end else begin
                if (ena[gi] && wea[gi]) mem[addra[gi]] <= dina[gi];
                if (ena[gi] && !wea[gi]) pipe[0] <= mem[addra[gi]];
                pipe[1] <= pipe[0];
                pipe[2] <= pipe[1];
            end
        end
        assign douta[gi] = pipe[L-1];
    end

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          free_at[NI], rv_at[NI], busy_lo[NI], busy_hi[NI];
    bit          last_cpu[NI], rv_cpu[NI];
    logic [31:0] sh[NI][128];
    logic [31:0] rv_data[NI];
    bit          e_ena[NI], e_wea[NI], e_cgnt[NI], e_lgnt[NI], e_crv[NI], e_lrv[NI], e_busy[NI];
    logic [6:0]  e_addr[NI];
    logic [31:0] e_din[NI], e_crd[NI], e_lrd[NI];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            free_at[i] = 0;  rv_at[i] = -1;  busy_lo[i] = 1;  busy_hi[i] = 0;
            last_cpu[i] = 1'b0;  rv_cpu[i] = 1'b0;  rv_data[i] = 32'h0;
            e_ena[i] = 0; e_wea[i] = 0; e_cgnt[i] = 0; e_lgnt[i] = 0;
            e_crv[i] = 0; e_lrv[i] = 0; e_busy[i] = 0;
            e_addr[i] = 7'h0; e_din[i] = 32'h0; e_crd[i] = 32'h0; e_lrd[i] = 32'h0;
            for (int k = 0; k < 128; k++) sh[i][k] = init_word(k);
        end
    endtask

    // Predicts the outputs visible in the next cycle from the current inputs.
    task automatic predict();
        for (int i = 0; i < NI; i++) begin
            bit          pc;
            bit          we;
            logic [6:0]  a;
            logic [31:0] d;
            e_cgnt[i] = 0; e_lgnt[i] = 0; e_crv[i] = 0; e_lrv[i] = 0;
            if (cyc + 1 == rv_at[i]) begin
                if (rv_cpu[i]) begin e_crv[i] = 1; e_crd[i] = rv_data[i]; end
                else           begin e_lrv[i] = 1; e_lrd[i] = rv_data[i]; end
            end
            if (cyc >= free_at[i] && (cpu_req[i] || ldr_req[i])) begin
`ifdef DMEM_ARB_CPU_PRIO_EN
                pc = cpu_req[i];
`else
                pc = cpu_req[i] && (!ldr_req[i] || !last_cpu[i]);
`endif
                last_cpu[i] = pc;
                we = pc ? cpu_we[i]    : ldr_we[i];
                a  = pc ? cpu_addr[i]  : ldr_addr[i];
                d  = pc ? cpu_wdata[i] : ldr_wdata[i];
                e_ena[i] = 1; e_wea[i] = we; e_addr[i] = a; e_din[i] = d;
                if (pc) e_cgnt[i] = 1; else e_lgnt[i] = 1;
                if (we) begin
                    sh[i][a] = d;
                end else begin
                    rv_at[i]   = cyc + lat_of(i) + 2;
                    rv_cpu[i]  = pc;
                    rv_data[i] = sh[i][a];
                    busy_lo[i] = cyc + 1;
                    busy_hi[i] = cyc + 1 + lat_of(i);
                    free_at[i] = cyc + lat_of(i) + 2;
                end
            end else begin
                e_ena[i] = 0; e_wea[i] = 0;
            end
            e_busy[i] = (cyc + 1 >= busy_lo[i]) && (cyc + 1 <= busy_hi[i]);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("i%0d_ena", i),        32'(ena[i]),        32'(e_ena[i]));
            chk($sformatf("i%0d_wea", i),        32'(wea[i]),        32'(e_wea[i]));
            chk($sformatf("i%0d_addra", i),      32'(addra[i]),      32'(e_addr[i]));
            chk($sformatf("i%0d_dina", i),       dina[i],            e_din[i]);
            chk($sformatf("i%0d_cpu_gnt", i),    32'(cpu_gnt[i]),    32'(e_cgnt[i]));
            chk($sformatf("i%0d_ldr_gnt", i),    32'(ldr_gnt[i]),    32'(e_lgnt[i]));
            chk($sformatf("i%0d_cpu_rvalid", i), 32'(cpu_rvalid[i]), 32'(e_crv[i]));
            chk($sformatf("i%0d_ldr_rvalid", i), 32'(ldr_rvalid[i]), 32'(e_lrv[i]));
            chk($sformatf("i%0d_cpu_rdata", i),  cpu_rdata[i],       e_crd[i]);
            chk($sformatf("i%0d_ldr_rdata", i),  ldr_rdata[i],       e_lrd[i]);
            chk($sformatf("i%0d_busy", i),       32'(busy[i]),       32'(e_busy[i]));
        end
        $display("[TB] cyc=%0d i0 ena=%0b wea=%0b a=%h cg=%0b lg=%0b crv=%0b lrv=%0b busy=%0b | i1 cg=%0b lg=%0b crv=%0b lrv=%0b busy=%0b",
                 cyc, ena[0], wea[0], addra[0], cpu_gnt[0], ldr_gnt[0], cpu_rvalid[0], ldr_rvalid[0],
                 busy[0], cpu_gnt[1], ldr_gnt[1], cpu_rvalid[1], ldr_rvalid[1], busy[1]);
    endtask

    task automatic step();
        predict();
        @(posedge clk);
        #1;
        cyc++;
        check_all();
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < NI; i++) begin
            cpu_req[i] = 0; cpu_we[i] = 0; cpu_addr[i] = 7'h0; cpu_wdata[i] = 32'h0;
            ldr_req[i] = 0; ldr_we[i] = 0; ldr_addr[i] = 7'h0; ldr_wdata[i] = 32'h0;
        end
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        cyc++;
        check_all();
        rst = 1'b0;
    endtask

    function automatic logic [6:0] rand_addr();
        int r;
        r = int'($urandom_range(0, 7));
        if (r == 0) return 7'h7F;
        if (r == 1) return 7'h00;
        return 7'($urandom_range(0, 127));
    endfunction

    initial begin
        int g_c, rv_c, lg_c, rv_seen;
        clear_inputs();
        rst = 1'b1;
        model_reset();
        #12;
        check_all();
        do_reset();

        // Lone CPU store.
        cpu_req[0] = 1; cpu_we[0] = 1; cpu_addr[0] = 7'h05; cpu_wdata[0] = 32'hDEADBEEF;
        step();
        chk("t1_ena", 32'(ena[0]), 32'd1);
        chk("t1_wea", 32'(wea[0]), 32'd1);
        chk("t1_addra", 32'(addra[0]), 32'h05);
        chk("t1_dina", dina[0], 32'hDEADBEEF);
        chk("t1_cpu_gnt", 32'(cpu_gnt[0]), 32'd1);
        chk("t1_busy", 32'(busy[0]), 32'd0);
        cpu_req[0] = 0;
        step();
        chk("t1_gnt_pulse", 32'(cpu_gnt[0]), 32'd0);
        chk("t1_no_rvalid", 32'(cpu_rvalid[0]), 32'd0);

        // Lone loader load with RD_LAT=1.
        ldr_req[0] = 1; ldr_we[0] = 0; ldr_addr[0] = 7'h05;
        step();
        chk("t2_ldr_gnt", 32'(ldr_gnt[0]), 32'd1);
        chk("t2_busy_c1", 32'(busy[0]), 32'd1);
        ldr_req[0] = 0;
        step();
        chk("t2_busy_c2", 32'(busy[0]), 32'd1);
        chk("t2_rvalid_c2", 32'(ldr_rvalid[0]), 32'd0);
        step();
        chk("t2_rvalid_c3", 32'(ldr_rvalid[0]), 32'd1);
        chk("t2_rdata", ldr_rdata[0], 32'hDEADBEEF);
        chk("t2_busy_c3", 32'(busy[0]), 32'd0);
        chk("t2_cpu_rvalid", 32'(cpu_rvalid[0]), 32'd0);
        step();
        chk("t2_rvalid_pulse", 32'(ldr_rvalid[0]), 32'd0);

        // Continuous store requests from both ports.
        do_reset();
        cpu_req[0] = 1; cpu_we[0] = 1; cpu_addr[0] = 7'h10; cpu_wdata[0] = 32'h1111_0000;
        ldr_req[0] = 1; ldr_we[0] = 1; ldr_addr[0] = 7'h11; ldr_wdata[0] = 32'h2222_0000;
        for (int k = 0; k < 6; k++) begin
            cpu_wdata[0] = 32'h1111_0000 + 32'(k);
            ldr_wdata[0] = 32'h2222_0000 + 32'(k);
            step();
`ifdef DMEM_ARB_CPU_PRIO_EN
            chk($sformatf("t3_cpu_gnt_%0d", k), 32'(cpu_gnt[0]), 32'd1);
`else
            chk($sformatf("t3_cpu_gnt_%0d", k), 32'(cpu_gnt[0]), 32'(k % 2 == 0));
            chk($sformatf("t3_ldr_gnt_%0d", k), 32'(ldr_gnt[0]), 32'(k % 2 == 1));
`endif
        end
        clear_inputs();
        step();

        // CPU load with RD_LAT=3 while the loader waits.
        cpu_req[1] = 1; cpu_we[1] = 0; cpu_addr[1] = 7'h20;
        ldr_req[1] = 1; ldr_we[1] = 1; ldr_addr[1] = 7'h21; ldr_wdata[1] = 32'hA5A5_0001;
        step();
        chk("t4_cpu_gnt", 32'(cpu_gnt[1]), 32'd1);
        cpu_req[1] = 0;
        g_c = cyc; rv_c = -100; lg_c = -1;
        for (int k = 0; k < 12 && lg_c < 0; k++) begin
            step();
            if (cpu_rvalid[1]) rv_c = cyc;
            if (ldr_gnt[1]) begin lg_c = cyc; ldr_req[1] = 0; end
        end
        chk("t4_rv_latency", 32'(rv_c - g_c), 32'd4);
        chk("t4_ldr_gnt_gap", 32'(lg_c - rv_c), 32'd1);
        chk("t4_rdata", cpu_rdata[1], init_word(32'h20));
        clear_inputs();
        step();

        // Reset one cycle after a load grant.
        cpu_req[0] = 1; cpu_we[0] = 0; cpu_addr[0] = 7'h30;
        step();
        chk("t5_cpu_gnt", 32'(cpu_gnt[0]), 32'd1);
        cpu_req[0] = 0;
        step();
        rst = 1'b1;
        #1;
        chk("t5_rst_ena", 32'(ena[0]), 32'd0);
        chk("t5_rst_busy", 32'(busy[0]), 32'd0);
        chk("t5_rst_addra", 32'(addra[0]), 32'd0);
        chk("t5_rst_gnt", 32'(cpu_gnt[0]), 32'd0);
        chk("t5_rst_rdata", cpu_rdata[0], 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        cyc++;
        check_all();
        rst = 1'b0;
        rv_seen = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            if (cpu_rvalid[0] || ldr_rvalid[0]) rv_seen++;
        end
        chk("t5_no_rvalid", 32'(rv_seen), 32'd0);
        cpu_req[0] = 1; cpu_we[0] = 1; cpu_addr[0] = 7'h31; cpu_wdata[0] = 32'h3131_3131;
        ldr_req[0] = 1; ldr_we[0] = 1; ldr_addr[0] = 7'h32; ldr_wdata[0] = 32'h3232_3232;
        step();
        chk("t5_tie_cpu", 32'(cpu_gnt[0]), 32'd1);
        chk("t5_tie_ldr", 32'(ldr_gnt[0]), 32'd0);
        cpu_req[0] = 0;
        step();
        chk("t5_ldr_next", 32'(ldr_gnt[0]), 32'd1);
        clear_inputs();
        step();

        // Top-of-range address: store then load.
        cpu_req[0] = 1; cpu_we[0] = 1; cpu_addr[0] = 7'h7F; cpu_wdata[0] = 32'h0000_0001;
        step();
        chk("t6_st_addra", 32'(addra[0]), 32'h7F);
        cpu_we[0] = 0;
        step();
        chk("t6_ld_addra", 32'(addra[0]), 32'h7F);
        chk("t6_ld_wea", 32'(wea[0]), 32'd0);
        cpu_req[0] = 0;
        step();
        step();
        chk("t6_rvalid", 32'(cpu_rvalid[0]), 32'd1);
        chk("t6_rdata", cpu_rdata[0], 32'h0000_0001);
        clear_inputs();
        step();

        // Random traffic on both instances.
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < NI; i++) begin
                if (e_cgnt[i]) cpu_req[i] = 0;
                else if (cpu_req[i] && $urandom_range(0, 19) == 0) cpu_req[i] = 0;
                if (!cpu_req[i] && $urandom_range(0, 2) == 0) begin
                    cpu_req[i] = 1; cpu_we[i] = 1'($urandom_range(0, 1));
                    cpu_addr[i] = rand_addr(); cpu_wdata[i] = $urandom;
                end
                if (e_lgnt[i]) ldr_req[i] = 0;
                else if (ldr_req[i] && $urandom_range(0, 19) == 0) ldr_req[i] = 0;
                if (!ldr_req[i] && $urandom_range(0, 2) == 0) begin
                    ldr_req[i] = 1; ldr_we[i] = 1'($urandom_range(0, 1));
                    ldr_addr[i] = rand_addr(); ldr_wdata[i] = $urandom;
                end
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
